calc_digits: RTL and testbench

Parametrised successor of the single-operand-pair keypad calculator. It takes keypad commands with a valid strobe, builds operands A and B in decimal, and computes `+`, `-` or `*`. Multiplication runs on a sequential shift-add unit. Results are converted to BCD by a sequential converter and scanned out one digit per cycle on `data`/`pos`. It sits between the keypad decoder and the 7-segment display controller.

---
 rtl/calc_digits_pkg.sv | 28 ++
 rtl/calc_digits_bin2bcd_seq.sv | 69 ++++++
 rtl/calc_digits.sv | 256 +++++++++++++++++++++++++
 tb/tb_calc_digits.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_digits_pkg.sv
// Shared types and encodings for the keypad calculator: FSM states,
// keypad command codes, status codes and the blank display digit.
package calc_digits_pkg;

    typedef enum logic [2:0] {
        StWaitA,
        StWaitB,
        StMul,
        StConv,
        StPrint,
        StErr
    } state_e;

    localparam logic [3:0] CMD_ADD = 4'd10;
    localparam logic [3:0] CMD_SUB = 4'd11;
    localparam logic [3:0] CMD_MUL = 4'd12;
    localparam logic [3:0] CMD_CLR = 4'd13;
    localparam logic [3:0] CMD_EQ  = 4'd14;
    localparam logic [3:0] CMD_BS  = 4'd15;

    localparam logic [1:0] STATUS_ERR   = 2'b00;
    localparam logic [1:0] STATUS_BUSY  = 2'b01;
    localparam logic [1:0] STATUS_READY = 2'b10;
    localparam logic [1:0] STATUS_PRINT = 2'b11;

    localparam logic [3:0] BLANK = 4'hF;

endpackage

// File: rtl/calc_digits_bin2bcd_seq.sv
// Iterative double-dabble: converts a W-bit binary value to NDIG BCD digits,
// one input bit per cycle, W cycles from start_i to done_o.
module bin2bcd_seq #(
    parameter int unsigned W    = 27,
    parameter int unsigned NDIG = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start_i,
    input  logic [W-1:0]      bin_i,
    output logic              done_o,
    output logic [NDIG*4-1:0] bcd_o
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]      sh_q, sh_d;
    logic [NDIG*4-1:0] bcd_q, bcd_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              busy_q, busy_d;

    function automatic logic [NDIG*4-1:0] dabble(input logic [NDIG*4-1:0] b, input logic bit_in);
        logic [NDIG*4-1:0] a;
        for (int unsigned i = 0; i < NDIG; i++) begin
            a[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return {a[NDIG*4-2:0], bit_in};
    endfunction

    // The load cycle already shifts in the MSB, so W-1 further cycles finish the job.
    always_comb begin
        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            bcd_d  = dabble('0, bin_i[W-1]);
            sh_d   = bin_i << 1;
            cnt_d  = CW'(W - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                bcd_d = dabble(bcd_q, sh_q[W-1]);
                sh_d  = sh_q << 1;
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign done_o = busy_q && (cnt_q == '0);
    assign bcd_o  = bcd_q;

endmodule

// File: rtl/calc_digits.sv
// Keypad calculator: decimal operand entry, + - *, BCD scan-out to the display.
// Build option CALC_DIGITS_NEG_EN enables signed subtraction and the neg output.
module calc_digits
    import calc_digits_pkg::*;
#(
    parameter int unsigned NDIG = 8,
    parameter int unsigned W    = 27
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [3:0]              cmd_i,
    input  logic                    cmd_valid_i,
    output logic [1:0]              status_o,
    output logic [3:0]              data_o,
    output logic [$clog2(NDIG)-1:0] pos_o,
    output logic                    neg_o
);

    localparam int unsigned PW   = $clog2(NDIG);
    localparam int unsigned CNTW = $clog2(NDIG + 1);
    localparam int unsigned MCW  = $clog2(W);
    localparam logic [2*W-1:0] MaxVal = (2*W)'(10**NDIG - 1);

`ifdef CALC_DIGITS_NEG_EN
    localparam bit NegEn = 1'b1;
`else
    localparam bit NegEn = 1'b0;
`endif

    state_e            state_q;
    logic [W-1:0]      a_q, entry_q, mplier_q;
    logic [2*W-1:0]    prod_q, mcand_q;
    logic [MCW-1:0]    mcnt_q;
    logic [3:0]        op_q, data_q;
    logic [CNTW-1:0]   cnt_q;
    logic [PW-1:0]     pos_q, msd_q;
    logic              neg_q, res_q, in_b_q;

    logic              acc, is_dig, is_op, a_lt_b;
    logic              go_conv, go_err, go_mul, conv_done;
    logic [W-1:0]      entry_dig, entry_bs, diff, conv_val;
    logic [W:0]        sum;
    logic [2*W-1:0]    prod_nx;
    logic [NDIG*4-1:0] conv_bcd;
    logic [PW-1:0]     msd_c, pos_nx;
    logic [3:0]        dig_nx;

    always_comb begin
        acc = cmd_valid_i && ((state_q == StWaitA) || (state_q == StWaitB) ||
                              ((state_q == StErr) && (cmd_i == CMD_CLR)));
        is_dig    = cmd_i <= 4'd9;
        is_op     = (cmd_i == CMD_ADD) || (cmd_i == CMD_SUB) || (cmd_i == CMD_MUL);
        entry_dig = res_q ? W'(cmd_i) : entry_q * W'(10) + W'(cmd_i);
        entry_bs  = entry_q / W'(10);
        sum       = {1'b0, a_q} + {1'b0, entry_q};
        a_lt_b    = a_q < entry_q;
        diff      = a_lt_b ? entry_q - a_q : a_q - entry_q;
        prod_nx   = prod_q + (mplier_q[0] ? mcand_q : '0);

        go_conv  = 1'b0;
        go_err   = 1'b0;
        go_mul   = 1'b0;
        conv_val = '0;
        if (state_q == StMul) begin
            if (mcnt_q == MCW'(W - 1)) begin
                if (prod_nx > MaxVal) begin
                    go_err = 1'b1;
                end else begin
                    go_conv  = 1'b1;
                    conv_val = prod_nx[W-1:0];
                end
            end
        end else if (acc) begin
            if (cmd_i == CMD_CLR) begin
                go_conv = 1'b1;
            end else if (is_dig) begin
                if (res_q || (cnt_q < CNTW'(NDIG))) begin
                    go_conv  = 1'b1;
                    conv_val = entry_dig;
                end
            end else if (cmd_i == CMD_BS) begin
                go_conv  = 1'b1;
                conv_val = entry_bs;
            end else if (is_op) begin
                if ((state_q == StWaitB) || (NegEn && neg_q)) go_err = 1'b1;
                else go_conv = 1'b1;
            end else if (state_q == StWaitB) begin
                case (op_q)
                    CMD_ADD: begin
                        if ((2*W)'(sum) > MaxVal) go_err = 1'b1;
                        else begin
                            go_conv  = 1'b1;
                            conv_val = sum[W-1:0];
                        end
                    end
                    CMD_SUB: begin
                        if (a_lt_b && !NegEn) go_err = 1'b1;
                        else begin
                            go_conv  = 1'b1;
                            conv_val = diff;
                        end
                    end
                    default: go_mul = 1'b1;
                endcase
            end
        end
    end

    // Position of the most significant non-zero digit; digits above it print blank.
    always_comb begin
        msd_c = '0;
        for (int unsigned k = 1; k < NDIG; k++) begin
            if (conv_bcd[4*k +: 4] != 4'd0) msd_c = PW'(k);
        end
        pos_nx = pos_q + 1'b1;
        dig_nx = (pos_nx > msd_q) ? BLANK : conv_bcd[{pos_nx, 2'b00} +: 4];
    end

    bin2bcd_seq #(
        .W   (W),
        .NDIG(NDIG)
    ) u_bin2bcd (
        .clock  (clock),
        .reset  (reset),
        .start_i(go_conv),
        .bin_i  (conv_val),
        .done_o (conv_done),
        .bcd_o  (conv_bcd)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StWaitA;
            a_q      <= '0;
            entry_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            mcand_q  <= '0;
            mcnt_q   <= '0;
            op_q     <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            pos_q    <= '0;
            msd_q    <= '0;
            neg_q    <= 1'b0;
            res_q    <= 1'b0;
            in_b_q   <= 1'b0;
        end else begin
            case (state_q)
                StWaitA, StWaitB, StErr: begin
                    if (acc) begin
                        if (cmd_i == CMD_CLR) begin
                            a_q     <= '0;
                            entry_q <= '0;
                            op_q    <= '0;
                            cnt_q   <= '0;
                            neg_q   <= 1'b0;
                            res_q   <= 1'b0;
                            in_b_q  <= 1'b0;
                        end else if (is_dig) begin
                            if (res_q) begin
                                entry_q <= entry_dig;
                                cnt_q   <= CNTW'(1);
                                neg_q   <= 1'b0;
                                res_q   <= 1'b0;
                            end else if (go_conv) begin
                                entry_q <= entry_dig;
                                cnt_q   <= cnt_q + 1'b1;
                            end
                        end else if (cmd_i == CMD_BS) begin
                            entry_q <= entry_bs;
                            res_q   <= 1'b0;
                            if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                        end else if (is_op) begin
                            if (!go_err) begin
                                a_q     <= entry_q;
                                op_q    <= cmd_i;
                                entry_q <= '0;
                                cnt_q   <= '0;
                                res_q   <= 1'b0;
                                in_b_q  <= 1'b1;
                            end
                        end else if (state_q == StWaitB) begin
                            if (go_mul) begin
                                mcand_q  <= {{W{1'b0}}, a_q};
                                mplier_q <= entry_q;
                                prod_q   <= '0;
                                mcnt_q   <= '0;
                            end else if (go_conv) begin
                                entry_q <= conv_val;
                                neg_q   <= NegEn && (op_q == CMD_SUB) && a_lt_b;
                                res_q   <= 1'b1;
                                in_b_q  <= 1'b0;
                            end
                        end
                        if (go_err)       state_q <= StErr;
                        else if (go_mul)  state_q <= StMul;
                        else if (go_conv) state_q <= StConv;
                    end
                end
                StMul: begin
                    prod_q   <= prod_nx;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    mcnt_q   <= mcnt_q + 1'b1;
                    if (go_err) begin
                        state_q <= StErr;
                    end else if (go_conv) begin
                        entry_q <= conv_val;
                        neg_q   <= 1'b0;
                        res_q   <= 1'b1;
                        in_b_q  <= 1'b0;
                        state_q <= StConv;
                    end
                end
                StConv: begin
                    if (conv_done) begin
                        state_q <= StPrint;
                        pos_q   <= '0;
                        data_q  <= conv_bcd[3:0];
                        msd_q   <= msd_c;
                        // A fresh result takes its digit count from the converted value.
                        if (res_q) cnt_q <= (conv_bcd == '0) ? '0 : CNTW'(msd_c) + 1'b1;
                    end
                end
                StPrint: begin
                    if (pos_q == PW'(NDIG - 1)) begin
                        state_q <= in_b_q ? StWaitB : StWaitA;
                    end else begin
                        pos_q  <= pos_nx;
                        data_q <= dig_nx;
                    end
                end
                default: state_q <= StErr;
            endcase
        end
    end

    always_comb begin
        case (state_q)
            StWaitA, StWaitB: status_o = STATUS_READY;
            StMul, StConv:    status_o = STATUS_BUSY;
            StPrint:          status_o = STATUS_PRINT;
            default:          status_o = STATUS_ERR;
        endcase
    end

    assign data_o = data_q;
    assign pos_o  = pos_q;
`ifdef CALC_DIGITS_NEG_EN
    assign neg_o = neg_q;
`else
    assign neg_o = 1'b0;
`endif

endmodule

// File: tb/tb_calc_digits.sv
// Self-checking bench for calc_digits: table of keypad commands with expected
// status, scanned-out display word, neg flag and completion latency.
module tb_calc_digits;

    localparam int NDIG = 8;
    localparam int W    = 27;
    localparam int L    = W + NDIG + 1;
    localparam int LM   = 2 * W + NDIG + 1;
    localparam int LOV  = W + 1;

    localparam logic [3:0] ADD = 4'd10, SUB = 4'd11, MUL = 4'd12;
    localparam logic [3:0] CLR = 4'd13, EQ = 4'd14, BS = 4'd15;
    localparam logic [1:0] RDY = 2'b10, ERR = 2'b00, BSY = 2'b01;

`ifdef CALC_DIGITS_NEG_EN
    localparam bit NegEn = 1'b1;
`else
    localparam bit NegEn = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] cmd;
    logic       cmd_valid;
    logic [1:0] status;
    logic [3:0] data;
    logic [2:0] pos;
    logic       neg;

    calc_digits #(
        .NDIG(NDIG),
        .W   (W)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_i      (cmd),
        .cmd_valid_i(cmd_valid),
        .status_o   (status),
        .data_o     (data),
        .pos_o      (pos),
        .neg_o      (neg)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  c;
        logic [1:0]  st;
        logic [31:0] shown;
        logic        ng;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    int          errors;
    int          checks;
    logic [31:0] shown;
    int          first_pr;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic add(input logic [3:0] c, input logic [1:0] st, input logic [31:0] sh,
                       input logic ng, input int lat);
        vec_t v;
        v.c = c; v.st = st; v.shown = sh; v.ng = ng; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Called #1 after an edge; samples each cycle until status is ready or error.
    task automatic capture(input int n0, output int n);
        n = n0;
        first_pr = 0;
        while (n < 200) begin
            if (status == 2'b11) begin
                if (first_pr == 0) first_pr = n;
                shown[int'(pos)*4 +: 4] = data;
            end
            if (status == RDY || status == ERR) break;
            @(posedge clock);
            #1;
            n++;
        end
        if (n >= 200) begin
            errors++;
            checks++;
            $display("FAIL capture_timeout: got busy after %0d cycles required idle", n);
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (status != RDY && status != ERR && k < 300) begin
            @(posedge clock);
            #1;
            k++;
        end
        if (k >= 300) begin
            errors++;
            checks++;
            $display("FAIL idle_timeout: got status %b required 10 or 00", status);
        end
    endtask

    task automatic run_cmd(input logic [3:0] c, output int lat);
        wait_idle();
        @(negedge clock);
        cmd = c;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        capture(1, lat);
    endtask

    initial begin
        logic [31:0] e;
        int          lat;

        reset = 1'b1; cmd = '0; cmd_valid = 1'b0;
        errors = 0; checks = 0; shown = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_status", {30'd0, status}, {30'd0, RDY});
        chk("reset_data", {28'd0, data}, 32'd0);
        chk("reset_pos", {29'd0, pos}, 32'd0);
        chk("reset_neg", {31'd0, neg}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        add(CLR,   RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd1,  RDY, 32'hFFFFFFF1, 1'b0, L);
        add(4'd2,  RDY, 32'hFFFFFF12, 1'b0, L);
        add(ADD,   RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd3,  RDY, 32'hFFFFFFF3, 1'b0, L);
        add(EQ,    RDY, 32'hFFFFFF15, 1'b0, L);
        add(ADD,   RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd5,  RDY, 32'hFFFFFFF5, 1'b0, L);
        add(EQ,    RDY, 32'hFFFFFF20, 1'b0, L);
        add(4'd9,  RDY, 32'hFFFFFFF9, 1'b0, L);
        add(EQ,    RDY, 32'hFFFFFFF9, 1'b0, 1);
        add(CLR,   RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd7,  RDY, 32'hFFFFFFF7, 1'b0, L);
        add(SUB,   RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd9,  RDY, 32'hFFFFFFF9, 1'b0, L);
        if (NegEn) begin
            add(EQ,  RDY, 32'hFFFFFFF2, 1'b1, L);
            add(ADD, ERR, 32'hFFFFFFF2, 1'b1, 1);
        end else begin
            add(EQ,  ERR, 32'hFFFFFFF9, 1'b0, 1);
            add(ADD, ERR, 32'hFFFFFFF9, 1'b0, 1);
        end
        add(CLR, RDY, 32'hFFFFFFF0, 1'b0, L);
        e = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            e = {e[27:0], 4'h9};
            add(4'd9, RDY, e, 1'b0, L);
        end
        add(MUL, RDY, 32'hFFFFFFF0, 1'b0, L);
        e = 32'hFFFFFFFF;
        for (int k = 0; k < 4; k++) begin
            e = {e[27:0], 4'h9};
            add(4'd9, RDY, e, 1'b0, L);
        end
        add(EQ,  RDY, 32'h99980001, 1'b0, LM);
        add(CLR, RDY, 32'hFFFFFFF0, 1'b0, L);
        e = 32'hFFFFFFFF;
        for (int k = 0; k < 8; k++) begin
            e = {e[27:0], 4'h9};
            add(4'd9, RDY, e, 1'b0, L);
        end
        add(MUL,  RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd2, RDY, 32'hFFFFFFF2, 1'b0, L);
        add(EQ,   ERR, 32'hFFFFFFF2, 1'b0, LOV);
        add(CLR,  RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd1, RDY, 32'hFFFFFFF1, 1'b0, L);
        add(4'd2, RDY, 32'hFFFFFF12, 1'b0, L);
        add(4'd3, RDY, 32'hFFFFF123, 1'b0, L);
        add(BS,   RDY, 32'hFFFFFF12, 1'b0, L);
        add(CLR,  RDY, 32'hFFFFFFF0, 1'b0, L);
        add(BS,   RDY, 32'hFFFFFFF0, 1'b0, L);
        e = 32'hFFFFFFFF;
        for (int k = 0; k < 8; k++) begin
            e = {e[27:0], 4'h1};
            add(4'd1, RDY, e, 1'b0, L);
        end
        add(4'd1, RDY, 32'h11111111, 1'b0, 1);
        add(CLR,  RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd1, RDY, 32'hFFFFFFF1, 1'b0, L);
        add(ADD,  RDY, 32'hFFFFFFF0, 1'b0, L);
        add(4'd2, RDY, 32'hFFFFFFF2, 1'b0, L);
        add(ADD,  ERR, 32'hFFFFFFF2, 1'b0, 1);
        add(CLR,  RDY, 32'hFFFFFFF0, 1'b0, L);

        foreach (vecs[i]) begin
            run_cmd(vecs[i].c, lat);
            chk($sformatf("v%0d_status", i), {30'd0, status}, {30'd0, vecs[i].st});
            chk($sformatf("v%0d_display", i), shown, vecs[i].shown);
            chk($sformatf("v%0d_neg", i), {31'd0, neg}, {31'd0, vecs[i].ng});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
        end

        // Digit pulse while busy must be dropped.
        wait_idle();
        @(negedge clock);
        cmd = 4'd4;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (3) @(negedge clock);
        chk("drop_busy_status", {30'd0, status}, {30'd0, BSY});
        cmd = 4'd5;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        capture(5, lat);
        chk("drop_display", shown, 32'hFFFFFFF4);
        chk("drop_status", {30'd0, status}, {30'd0, RDY});

        // Reset in the middle of a multiplication.
        run_cmd(CLR, lat);
        run_cmd(4'd3, lat);
        run_cmd(MUL, lat);
        run_cmd(4'd4, lat);
        wait_idle();
        @(negedge clock);
        cmd = EQ;
        cmd_valid = 1'b1;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        repeat (5) @(posedge clock);
        @(negedge clock);
        chk("mul_busy", {30'd0, status}, {30'd0, BSY});
        reset = 1'b1;
        #1;
        chk("rst_mul_status", {30'd0, status}, {30'd0, RDY});
        chk("rst_mul_pos", {29'd0, pos}, 32'd0);
        chk("rst_mul_data", {28'd0, data}, 32'd0);
        chk("rst_mul_neg", {31'd0, neg}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        run_cmd(4'd7, lat);
        chk("post_rst_display", shown, 32'hFFFFFFF7);
        chk("post_rst_first_print", first_pr, W + 1);
        chk("post_rst_latency", lat, L);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
